wts_i2s_tx: RTL and testbench
=============================

Name: wts_i2s_tx

Overview:
- Serialises the 12-bit stereo digital sound output of the wave table sound cartridge (left_out/right_out) into a standard I2S stream for an external audio DAC.
- Sits directly downstream of the cartridge top. Runs in the same 21.47727 MHz domain and shares its reset.
- Generates BCLK/LRCK as a clock master and snapshots both channels once per frame, so left and right always come from the same sample.

Parameters:
- BCLK_DIV, 7, half-period of i2s_bclk in clk cycles; must be >= 1. Default gives BCLK = clk/14 = 1.534 MHz and fs = clk/448 = 47.94 kHz.

Ports:
- clk  input  1  21.47727 MHz system clock
- nreset  input  1  asynchronous reset, active-low
- left_in  input  12  left sample, unsigned offset-binary (0x800 = midscale)
- right_in  input  12  right sample, unsigned offset-binary
- i2s_bclk  output  1  bit clock
- i2s_lrck  output  1  word select; 0 = left, 1 = right
- i2s_sdata  output  1  serial data, changes on bclk falling edge
- sample_strobe  output  1  one-clk pulse when left_in/right_in are captured

Behaviour:
- Prescaler counts 0..BCLK_DIV-1. On wrap, i2s_bclk toggles. A 1->0 toggle is a "fall event".
- Bit index k (5 bits, 0..31) advances on each fall event and wraps 31->0.
- i2s_lrck = 0 for k = 0..15 and 1 for k = 16..31. It updates on the same clk edge as k.
- Slot word conversion: L16 = {~left_in[11], left_in[10:0], 4'b0000}; R16 is formed the same way from right_in. W = {L16, R16}, 32 bits, with the MSB at index 31.
- Capture: on the fall event that enters k = 0, W is loaded from the current inputs. sample_strobe is 1 for exactly that clk cycle. Input changes at any other time are ignored until the next capture.
- I2S data timing (default): with k = 0, i2s_sdata = W_prev[0] (the previous frame's right LSB). With k = 1..31, i2s_sdata = W[32-k]. This gives the one-BCLK delay after each LRCK transition.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Frame period is 64*BCLK_DIV clk cycles. sample_strobe period is the same.
- Reset values: prescaler 0, i2s_bclk 0, k = 31, i2s_lrck 1, i2s_sdata 0, W and W_prev 0, sample_strobe 0.
- After reset deassertion: the first bclk rise is BCLK_DIV clks later and the first fall event is 2*BCLK_DIV clks later. That fall event captures the inputs, pulses the strobe and enters k = 0.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). No partial frame resumes.
- BCLK_DIV = 1: i2s_bclk = clk/2; a fall event occurs every 2 clks. Behaviour is otherwise identical.

Optional Feature:
- Macro WTS_I2S_LEFT_JUSTIFIED_EN.
- Defined: left-justified format with no one-bit delay: i2s_sdata = W[31-k] for all k, and W_prev is not implemented. Left MSB coincides with LRCK falling; right MSB coincides with LRCK rising.
- Undefined: standard I2S timing as described in Behaviour.
- LRCK, BCLK, capture and strobe timing are the same in both modes.

Decomposition:
- Package wts_i2s_pkg holds:
  - SLOT_BITS = 16, FRAME_BITS = 32, SAMPLE_BITS = 12.
  - LRCK_LEFT = 1'b0.
  - A function for the offset-binary to 16-bit two's-complement slot conversion.
- Sub-module wts_i2s_clkgen holds the prescaler, the i2s_bclk register and the fall-event enable. The top holds k, lrck, W/W_prev and sdata.

Test Plan:
- Reset release with BCLK_DIV = 7 -> first sample_strobe 14 clks after nreset rises; subsequent strobes every 448 clks; i2s_bclk period 14 clks; i2s_lrck period 448 clks.
- left_in = 0xFFF, right_in = 0x000 -> I2S mode: bits k = 1..16 read 0x7FF0 and bits k = 17..31 plus the next frame's k = 0 read 0x8000, MSB first.
- left_in = 0x800, right_in = 0x123 -> left slot 0x0000, right slot 0x9230; the right LSB (0) appears at k = 0 of the following frame.
- Change left_in every clk with a counter pattern -> the transmitted slot equals the value present on the capture edge (the sample_strobe cycle) only.
- Assert nreset for 3 clks mid-frame at k = 20 -> outputs immediately return to bclk 0, lrck 1, sdata 0, strobe 0; restart timing matches the first scenario.
- Build with WTS_I2S_LEFT_JUSTIFIED_EN and left = 0xFFF -> i2s_sdata = 0 at k = 0 (the MSB of 0x7FF0), bits k = 0..15 read 0x7FF0, and the right MSB appears at k = 16.

Source files
------------

// File: rtl/wts_i2s_pkg.sv
// Shared constants and the sample-to-slot conversion for the wave table sound I2S transmitter.
package wts_i2s_pkg;

  localparam int unsigned SLOT_BITS   = 16;
  localparam int unsigned FRAME_BITS  = 32;
  localparam int unsigned SAMPLE_BITS = 12;

  localparam logic LRCK_LEFT = 1'b0;

  // Offset-binary sample to left-aligned 16-bit two's complement: flip the MSB, pad with zeros.
  function automatic logic [SLOT_BITS-1:0] to_slot(input logic [SAMPLE_BITS-1:0] s);
    return {~s[SAMPLE_BITS-1], s[SAMPLE_BITS-2:0], {(SLOT_BITS - SAMPLE_BITS){1'b0}}};
  endfunction

endpackage

// File: rtl/wts_i2s_clkgen.sv
// Bit-clock generator: prescaler, registered i2s_bclk and a one-clk enable on each bclk fall.
module wts_i2s_clkgen
  import wts_i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 7
) (
  input  logic clk,
  input  logic nreset,
  output logic bclk,
  output logic fall
);

  localparam int unsigned CntW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BCLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bclk_q, bclk_d;
  logic            wrap;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  always_comb begin
    wrap   = (cnt_q == CntMax);
    cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
    bclk_d = wrap ? ~bclk_q : bclk_q;
  end

  assign bclk = bclk_q;
  assign fall = wrap & bclk_q;

endmodule

// File: rtl/wts_i2s_tx.sv
// I2S master transmitter for the 12-bit stereo cartridge output.
// Define WTS_I2S_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit data delay).
module wts_i2s_tx
  import wts_i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 7
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [SAMPLE_BITS-1:0] left_in,
  input  logic [SAMPLE_BITS-1:0] right_in,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata,
  output logic                   sample_strobe
);

  logic                  bclk, fall, capture;
  logic [4:0]            k_q, k_d;
  logic                  lrck_q, lrck_d;
  logic [FRAME_BITS-1:0] w_q, w_d;
  logic                  sdata_q, sdata_d;
  logic                  strobe_q, strobe_d;

  wts_i2s_clkgen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clkgen (
    .clk   (clk),
    .nreset(nreset),
    .bclk  (bclk),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      k_q      <= 5'd31;
      lrck_q   <= ~LRCK_LEFT;
      w_q      <= '0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      lrck_q   <= lrck_d;
      w_q      <= w_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    capture  = fall && (k_q == 5'd31);
    k_d      = fall ? k_q + 5'd1 : k_q;
    lrck_d   = k_d[4] ? ~LRCK_LEFT : LRCK_LEFT;
    w_d      = capture ? {to_slot(left_in), to_slot(right_in)} : w_q;
    strobe_d = capture;
    sdata_d  = sdata_q;
    if (fall) begin
`ifdef WTS_I2S_LEFT_JUSTIFIED_EN
      sdata_d = w_d[~k_d];
`else
      // On the capture edge w_q is still the previous frame, so it stands in for W_prev.
      sdata_d = capture ? w_q[0] : w_d[5'(6'd32 - {1'b0, k_d})];
`endif
    end
  end

  assign i2s_bclk      = bclk;
  assign i2s_lrck      = lrck_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_wts_i2s_tx.sv
// Scoreboard bench for wts_i2s_tx: random/directed stimulus, reference frame queue, serial decoder.
module tb_wts_i2s_tx;

  localparam int unsigned D     = 7;
  localparam int unsigned FRAME = 64 * D;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [11:0] left_in = '0;
  logic [11:0] right_in = '0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe;

  wts_i2s_tx #(
    .BCLK_DIV(D)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .left_in      (left_in),
    .right_in     (right_in),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned e = 0;          // rising edges since reset release
  int          frames_cmp = 0;
  logic [31:0] exp_q[$];

  // Reference: offset-binary to signed, scaled by 16 into a 16-bit slot.
  function automatic logic [15:0] ref_slot(input logic [11:0] s);
    int v;
    v = (int'(s) - 2048) * 16;
    return v[15:0];
  endfunction

  // Bit index after edge ed: starts at 31, advances every 2*D edges.
  function automatic int ref_k(input int unsigned ed);
    return (31 + ed / (2 * D)) % 32;
  endfunction

  function automatic bit ref_cap(input int unsigned ed);
    return (ed >= 2 * D) && (ed % (2 * D) == 0) && (ref_k(ed) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!nreset) e = 0;
    else e = e + 1;
  end

  // Monitor: per-cycle waveform checks plus a serial decoder feeding the scoreboard.
  logic        bclk_prev = 1'b0;
  logic        lrck_last = 1'b1;
  logic [31:0] sr = '0;
  int          frames_seen = 0;

  task automatic cmp_frame();
    logic [31:0] exp;
    if (frames_seen > 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_queue: got frame %h expected none queued at t=%0t", sr, $time);
      end else begin
        exp = exp_q.pop_front();
        chk("frame_data", sr, exp);
        frames_cmp++;
      end
    end
    frames_seen++;
  endtask

  always @(negedge clk) begin
    if (!nreset) begin
      chk("rst_bclk", 32'(i2s_bclk), 32'd0);
      chk("rst_lrck", 32'(i2s_lrck), 32'd1);
      chk("rst_sdata", 32'(i2s_sdata), 32'd0);
      chk("rst_strobe", 32'(sample_strobe), 32'd0);
      bclk_prev   = 1'b0;
      lrck_last   = 1'b1;
      frames_seen = 0;
    end else begin
      chk("bclk", 32'(i2s_bclk), 32'((e / D) % 2));
      chk("lrck", 32'(i2s_lrck), 32'(ref_k(e) >= 16));
      chk("strobe", 32'(sample_strobe), 32'(ref_cap(e)));
      if (i2s_bclk && !bclk_prev) begin
`ifdef WTS_I2S_LEFT_JUSTIFIED_EN
        if (!i2s_lrck && lrck_last) cmp_frame();
        sr = {sr[30:0], i2s_sdata};
`else
        sr = {sr[30:0], i2s_sdata};
        if (!i2s_lrck && lrck_last) cmp_frame();
`endif
        lrck_last = i2s_lrck;
      end
      bclk_prev = i2s_bclk;
    end
  end

  // Stimulus: mode 0/1 directed constants, 2 left counter, 3 random per clk, 4 random held.
  task automatic drive(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (mode)
        0: begin left_in = 12'hFFF; right_in = 12'h000; end
        1: begin left_in = 12'h800; right_in = 12'h123; end
        2: begin left_in = left_in + 12'd1; right_in = 12'($urandom); end
        3: begin left_in = 12'($urandom); right_in = 12'($urandom); end
        default: if (i % 37 == 0) begin
          left_in  = 12'($urandom);
          right_in = 12'($urandom);
        end
      endcase
      if (nreset && ref_cap(e + 1)) exp_q.push_back({ref_slot(left_in), ref_slot(right_in)});
    end
  endtask

  initial begin
    int  guard;
    left_in  = 12'hFFF;
    right_in = 12'h000;
    repeat (3) @(negedge clk);
    #2 nreset = 1'b1;
    drive(3 * FRAME, 0);
    drive(3 * FRAME, 1);
    left_in = 12'h000;
    drive(3 * FRAME, 2);

    guard = 0;
    do begin
      drive(1, 3);
      guard++;
    end while (!(ref_k(e) == 20 && e % (2 * D) == 3) && guard < 2 * FRAME);
    chk("reach_k20", 32'(guard < 2 * FRAME), 32'd1);

    @(negedge clk);
    #2 nreset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_bclk", 32'(i2s_bclk), 32'd0);
    chk("async_rst_lrck", 32'(i2s_lrck), 32'd1);
    chk("async_rst_sdata", 32'(i2s_sdata), 32'd0);
    chk("async_rst_strobe", 32'(sample_strobe), 32'd0);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b1;
    drive(4 * FRAME, 3);
    drive(3 * FRAME, 4);

    chk("frames_compared", 32'(frames_cmp >= 12), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
